// File: rtl/usb2_ep_pkg.sv
// usb2_ep_pkg: endpoint mode and DATA PID selector encodings shared by endpoint and protocol layer
package usb2_ep_pkg;
  localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
  localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
  localparam logic [1:0] EP_MODE_BULK      = 2'd2;
  localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;
  localparam logic [1:0] DATA_TOGGLE_0 = 2'd0;
  localparam logic [1:0] DATA_TOGGLE_1 = 2'd1;
  localparam logic [1:0] DATA_TOGGLE_2 = 2'd2;
  localparam logic [1:0] DATA_TOGGLE_M = 2'd3;
endpackage

// File: rtl/usb2_ep_ram.sv
// usb2_ep_ram: single-clock simple dual-port byte RAM with registered read
module usb2_ep_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);
  logic [7:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/usb2_ep_ring.sv
// usb2_ep_ring: NBUF-slot endpoint packet ring with fill count, drop flag and isoch PID selection
module usb2_ep_ring
  import usb2_ep_pkg::*;
#(
  parameter int NBUF     = 4,
  parameter int BUF_AW   = 10,
  parameter int LEN_W    = 11,
  parameter int ISO_MULT = 3,
  localparam int PW      = $clog2(NBUF),
  localparam int CW      = $clog2(NBUF + 1)
) (
  input  logic              phy_clk,
  input  logic              reset,
  input  logic [BUF_AW-1:0] buf_in_addr,
  input  logic [7:0]        buf_in_data,
  input  logic              buf_in_wren,
  output logic              buf_in_ready,
  input  logic              buf_in_commit,
  input  logic [LEN_W-1:0]  buf_in_commit_len,
  output logic              buf_in_commit_ack,
  output logic              buf_in_drop,
  input  logic [BUF_AW-1:0] buf_out_addr,
  output logic [7:0]        buf_out_q,
  output logic [LEN_W-1:0]  buf_out_len,
  output logic              buf_out_hasdata,
  input  logic              buf_out_arm,
  output logic              buf_out_arm_ack,
  input  logic              buf_out_clear,
  output logic [CW-1:0]     fill_count,
  input  logic [1:0]        mode,
  input  logic              data_toggle_act,
  output logic [1:0]        data_toggle,
  input  logic              sof_arrived
);
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [LEN_W-1:0] len_q [NBUF];
  logic [LEN_W-1:0] len_d [NBUF];
  logic             commit_ack_q, commit_ack_d, drop_q, drop_d, arm_ack_q, arm_ack_d;
  logic [1:0]       tog_q, tog_d, iso_pid;
  logic             sof_q, sof_edge, arm_eff, accept;
  assign buf_in_ready      = count_q != CW'(NBUF);
  assign buf_out_hasdata   = count_q != '0;
  assign buf_out_len       = len_q[rd_ptr_q];
  assign fill_count        = count_q;
  assign buf_in_commit_ack = commit_ack_q;
  assign buf_in_drop       = drop_q;
  assign buf_out_arm_ack   = arm_ack_q;
  assign data_toggle       = tog_q;
  assign arm_eff  = buf_out_arm & buf_out_hasdata;
  assign accept   = buf_in_commit & (buf_in_ready | arm_eff);
  assign sof_edge = sof_arrived ^ sof_q;
  assign iso_pid  = count_q > CW'(ISO_MULT - 1) ? 2'(ISO_MULT - 1) : 2'(count_q);
  usb2_ep_ram #(.AW(PW + BUF_AW)) u_ram (
    .clk       (phy_clk),
    .wr_en_i   (buf_in_wren & buf_in_ready),
    .wr_addr_i ({wr_ptr_q, buf_in_addr}),
    .wr_data_i (buf_in_data),
    .rd_addr_i ({rd_ptr_q, buf_out_addr}),
    .rd_data_o (buf_out_q)
  );
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    len_d        = len_q;
    commit_ack_d = 1'b0;
    drop_d       = 1'b0;
    arm_ack_d    = 1'b0;
    if (buf_out_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      commit_ack_d = accept;
      drop_d       = buf_in_commit & ~accept;
      arm_ack_d    = buf_out_arm;
      if (accept) begin
        len_d[wr_ptr_q] = buf_in_commit_len;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      rd_ptr_d = arm_eff ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(accept) - CW'(arm_eff);
    end
  end
  // Isoch: SOF reloads the PID from the queue depth and outranks a same-cycle act.
  always_comb begin
    tog_d = tog_q;
    if (mode == EP_MODE_ISOCH)
      tog_d = sof_edge ? iso_pid : data_toggle_act ? (tog_q == DATA_TOGGLE_0 ? DATA_TOGGLE_0 : tog_q - 2'd1) : tog_q;
    else
      tog_d = data_toggle_act ? (tog_q == DATA_TOGGLE_0 ? DATA_TOGGLE_1 : DATA_TOGGLE_0) : tog_q;
  end
  always_ff @(posedge phy_clk) begin
    sof_q <= sof_arrived;
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      len_q        <= '{default: '0};
      commit_ack_q <= 1'b0;
      drop_q       <= 1'b0;
      arm_ack_q    <= 1'b0;
      tog_q        <= DATA_TOGGLE_0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      len_q        <= len_d;
      commit_ack_q <= commit_ack_d;
      drop_q       <= drop_d;
      arm_ack_q    <= arm_ack_d;
      tog_q        <= tog_d;
    end
  end
endmodule

// File: tb/tb_usb2_ep_ring.sv
// tb_usb2_ep_ring: directed self-checking bench for the endpoint ring
module tb_usb2_ep_ring;
  import usb2_ep_pkg::*;
  logic        phy_clk = 1'b0;
  logic        reset;
  logic [9:0]  buf_in_addr, buf_out_addr;
  logic [7:0]  buf_in_data, buf_out_q;
  logic        buf_in_wren, buf_in_ready, buf_in_commit, buf_in_commit_ack, buf_in_drop;
  logic [10:0] buf_in_commit_len, buf_out_len;
  logic        buf_out_hasdata, buf_out_arm, buf_out_arm_ack, buf_out_clear;
  logic [2:0]  fill_count;
  logic [1:0]  mode, data_toggle;
  logic        data_toggle_act, sof_arrived;
  int tests = 0;
  int fails = 0;
  usb2_ep_ring dut (
    .phy_clk(phy_clk), .reset(reset),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .buf_in_commit_ack(buf_in_commit_ack), .buf_in_drop(buf_in_drop),
    .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .buf_out_clear(buf_out_clear), .fill_count(fill_count), .mode(mode),
    .data_toggle_act(data_toggle_act), .data_toggle(data_toggle), .sof_arrived(sof_arrived)
  );
  always #5 phy_clk = ~phy_clk;
  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic commit(input logic [10:0] len);
    buf_in_commit = 1'b1;
    buf_in_commit_len = len;
    tick();
    buf_in_commit = 1'b0;
  endtask
  task automatic arm();
    buf_out_arm = 1'b1;
    tick();
    buf_out_arm = 1'b0;
  endtask
  task automatic act();
    data_toggle_act = 1'b1;
    tick();
    data_toggle_act = 1'b0;
  endtask
  initial begin
    reset = 1'b1; buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 1'b0;
    buf_in_commit = 1'b0; buf_in_commit_len = '0; buf_out_addr = '0; buf_out_arm = 1'b0;
    buf_out_clear = 1'b0; mode = EP_MODE_BULK; data_toggle_act = 1'b0; sof_arrived = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_fill", fill_count, 0);
    chk("rst_ready", buf_in_ready, 1);
    chk("rst_hasdata", buf_out_hasdata, 0);
    chk("rst_toggle", data_toggle, DATA_TOGGLE_0);
    chk("rst_len", buf_out_len, 0);
    chk("rst_ack", {buf_in_commit_ack, buf_in_drop, buf_out_arm_ack}, 0);
    buf_in_wren = 1'b1; buf_in_addr = 10'd7; buf_in_data = 8'hA5;
    tick();
    buf_in_wren = 1'b0;
    commit(11'd512);
    chk("c0_ack", buf_in_commit_ack, 1);
    chk("c0_fill", fill_count, 1);
    chk("c0_len", buf_out_len, 512);
    chk("c0_hasdata", buf_out_hasdata, 1);
    buf_out_addr = 10'd7;
    tick();
    chk("rd_a5", buf_out_q, 8'hA5);
    commit(11'd64);   chk("c1_ack", buf_in_commit_ack, 1);
    commit(11'd1024); chk("c2_ack", buf_in_commit_ack, 1);
    commit(11'd1);    chk("c3_ack", buf_in_commit_ack, 1);
    chk("full_fill", fill_count, 4);
    chk("full_ready", buf_in_ready, 0);
    commit(11'd5);
    chk("c4_drop", buf_in_drop, 1);
    chk("c4_noack", buf_in_commit_ack, 0);
    chk("c4_fill", fill_count, 4);
    buf_in_wren = 1'b1; buf_in_data = 8'h3C;
    tick();
    buf_in_wren = 1'b0;
    chk("drop_pulse_end", buf_in_drop, 0);
    tick();
    chk("full_wr_ignored", buf_out_q, 8'hA5);
    arm(); chk("a1_ack", buf_out_arm_ack, 1); chk("a1_len", buf_out_len, 64);
    arm(); chk("a2_len", buf_out_len, 1024);
    arm(); chk("a3_len", buf_out_len, 1); chk("a3_fill", fill_count, 1);
    commit(11'd10); commit(11'd20); commit(11'd30);
    chk("refill", fill_count, 4);
    buf_out_arm = 1'b1;
    commit(11'd40);
    buf_out_arm = 1'b0;
    chk("ca_ack", buf_in_commit_ack, 1);
    chk("ca_armack", buf_out_arm_ack, 1);
    chk("ca_fill", fill_count, 4);
    chk("ca_rdwrap", buf_out_len, 10);
    arm();
    chk("q3_len", buf_out_len, 20);
    chk("q3_fill", fill_count, 3);
    act();
    chk("bulk_pre", data_toggle, DATA_TOGGLE_1);
    buf_out_clear = 1'b1; buf_out_arm = 1'b1;
    tick();
    buf_out_clear = 1'b0; buf_out_arm = 1'b0;
    chk("clr_fill", fill_count, 0);
    chk("clr_hasdata", buf_out_hasdata, 0);
    chk("clr_noarmack", buf_out_arm_ack, 0);
    chk("clr_toggle", data_toggle, DATA_TOGGLE_1);
    commit(11'd77);
    chk("clr_ptr0", buf_out_len, 77);
    arm();
    chk("drain_fill", fill_count, 0);
    arm();
    chk("empty_armack", buf_out_arm_ack, 1);
    chk("empty_fill", fill_count, 0);
    act();
    act(); chk("bulk_t1", data_toggle, DATA_TOGGLE_1);
    act(); chk("bulk_t2", data_toggle, DATA_TOGGLE_0);
    act(); chk("bulk_t3", data_toggle, DATA_TOGGLE_1);
    sof_arrived = 1'b1; tick(); tick();
    chk("bulk_sof", data_toggle, DATA_TOGGLE_1);
    commit(11'd9);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_toggle", data_toggle, DATA_TOGGLE_0);
    chk("mid_rst_fill", fill_count, 0);
    chk("mid_rst_len", buf_out_len, 0);
    mode = EP_MODE_ISOCH;
    commit(11'd100); commit(11'd200);
    sof_arrived = 1'b0; tick();
    chk("iso_sof", data_toggle, DATA_TOGGLE_2);
    act(); chk("iso_a1", data_toggle, DATA_TOGGLE_1);
    act(); chk("iso_a2", data_toggle, DATA_TOGGLE_0);
    act(); chk("iso_a3", data_toggle, DATA_TOGGLE_0);
    commit(11'd1); commit(11'd2);
    sof_arrived = 1'b1; data_toggle_act = 1'b1;
    tick();
    data_toggle_act = 1'b0;
    chk("iso_sat_sofwins", data_toggle, DATA_TOGGLE_2);
    arm(); arm(); arm();
    sof_arrived = 1'b0; tick();
    chk("iso_sof_one", data_toggle, DATA_TOGGLE_1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
